// File: rtl/dmem_access_ctrl.sv
//==============================================================================
// Module      : dmem_access_ctrl
// Description : Sequencer between the MEM stage and data_mem. Aligned accesses
//               pass through; misaligned ones use full-line read-modify-write,
//               and line-crossing ones are split over two cycles.
//               Optional feature macro: DMEM_MISALIGN_SPLIT_EN
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef DMEM_MEMTYPE_DEFS
`define DMEM_MEMTYPE_DEFS
`define MemTypeBusBits 2:0
`define DataBusBits    63:0
`define MemTypeB       3'd1
`define MemTypeH       3'd2
`define MemTypeW       3'd3
`define MemTypeD       3'd4
`define MemTypeBU      3'd5
`define MemTypeHU      3'd6
`define MemTypeWU      3'd7
`endif

module dmem_access_ctrl #(
    parameter int MEM_LINES = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [`MemTypeBusBits] req_memType,
    input  logic [`DataBusBits]    req_addr,
    input  logic [`DataBusBits]    req_wd,
    output logic                   req_ready,
    output logic [`DataBusBits]    rsp_rd,
    output logic                   misalign_err,
    output logic [31:0]            split_cnt,
    output logic                   mem_we,
    output logic [`MemTypeBusBits] mem_memType,
    output logic [`DataBusBits]    mem_addr,
    output logic [`DataBusBits]    mem_wd,
    input  logic [`DataBusBits]    mem_rd
);

    localparam int c_line_w = $clog2(MEM_LINES);
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit c_split_en = 1'b1;
`else
    localparam bit c_split_en = 1'b0;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_SECOND = 1'b1} state_t;

    state_t                r_state;
    logic [2:0]            r_type;
    logic [2:0]            r_off;
    logic [c_line_w-1:0]   r_line;
    logic [63:0]           r_wd;
    logic                  r_we;
    logic [63:0]           r_lo_line;
    logic [31:0]           r_split_cnt;

    function automatic logic [3:0] f_size(input logic [2:0] t);
        case (t)
            `MemTypeB, `MemTypeBU: f_size = 4'd1;
            `MemTypeH, `MemTypeHU: f_size = 4'd2;
            `MemTypeW, `MemTypeWU: f_size = 4'd4;
            `MemTypeD:             f_size = 4'd8;
            default:               f_size = 4'd0;
        endcase
    endfunction

    function automatic logic [63:0] f_mask(input logic [3:0] sz);
        case (sz)
            4'd1:    f_mask = 64'h0000_0000_0000_00FF;
            4'd2:    f_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    f_mask = 64'h0000_0000_FFFF_FFFF;
            4'd8:    f_mask = '1;
            default: f_mask = '0;
        endcase
    endfunction

    function automatic logic [63:0] f_extract(input logic [63:0] v, input logic [2:0] t);
        case (t)
            `MemTypeB:  f_extract = {{56{v[7]}},  v[7:0]};
            `MemTypeH:  f_extract = {{48{v[15]}}, v[15:0]};
            `MemTypeW:  f_extract = {{32{v[31]}}, v[31:0]};
            `MemTypeBU: f_extract = {56'd0, v[7:0]};
            `MemTypeHU: f_extract = {48'd0, v[15:0]};
            `MemTypeWU: f_extract = {32'd0, v[31:0]};
            `MemTypeD:  f_extract = v;
            default:    f_extract = '0;
        endcase
    endfunction

    // In SECOND every decode comes from the latched request, never from req_*.
    logic                w_second;
    logic [2:0]          w_type;
    logic [2:0]          w_off;
    logic [c_line_w-1:0] w_line;
    logic [c_line_w-1:0] w_line_sel;
    logic [63:0]         w_wd;
    logic [3:0]          w_size;
    logic                w_known;
    logic                w_mis;
    logic                w_cross;
    logic [5:0]          w_shamt;
    logic [127:0]        w_mask128;
    logic [127:0]        w_data128;
    logic [127:0]        w_rd128;
    logic [63:0]         w_half_mask;
    logic [63:0]         w_half_data;
    logic [63:0]         w_merge;
    logic [63:0]         w_load;
    logic [63:0]         w_line_base;
    logic                w_go_split;

    assign w_second    = (r_state == S_SECOND);
    assign w_type      = w_second ? r_type : req_memType;
    assign w_off       = w_second ? r_off  : req_addr[2:0];
    assign w_line      = w_second ? r_line : req_addr[3 +: c_line_w];
    assign w_wd        = w_second ? r_wd   : req_wd;
    assign w_size      = f_size(w_type);
    assign w_known     = (w_size != 4'd0);
    assign w_mis       = w_known && (({1'b0, w_off} & (w_size - 4'd1)) != 4'd0);
    assign w_cross     = w_known && (({1'b0, w_off} + w_size) > 4'd8);
    assign w_shamt     = {w_off, 3'b000};
    assign w_mask128   = {64'd0, f_mask(w_size)} << w_shamt;
    assign w_data128   = {64'd0, w_wd} << w_shamt;
    assign w_rd128     = w_second ? {mem_rd, r_lo_line} : {64'd0, mem_rd};
    assign w_half_mask = w_second ? w_mask128[127:64] : w_mask128[63:0];
    assign w_half_data = w_second ? w_data128[127:64] : w_data128[63:0];
    assign w_merge     = (mem_rd & ~w_half_mask) | (w_half_data & w_half_mask);
    assign w_load      = f_extract(64'(w_rd128 >> w_shamt), w_type);
    assign w_line_sel  = !w_second ? w_line :
                         (w_line == c_line_w'(MEM_LINES - 1)) ? '0 : w_line + c_line_w'(1);

    always_comb begin
        w_line_base = '0;
        w_line_base[3 +: c_line_w] = w_line_sel;
    end

    always_comb begin
        req_ready    = 1'b1;
        mem_we       = 1'b0;
        mem_memType  = req_memType;
        mem_addr     = req_addr;
        mem_wd       = req_wd;
        rsp_rd       = '0;
        misalign_err = 1'b0;
        w_go_split   = 1'b0;
        if (rst) begin
            req_ready = 1'b1;
        end else if (w_second) begin
            mem_memType = `MemTypeD;
            mem_addr    = w_line_base;
            mem_we      = r_we;
            mem_wd      = w_merge;
            rsp_rd      = r_we ? 64'd0 : w_load;
        end else if (req_valid && w_known) begin
            if (!w_mis) begin
                mem_we = req_we;
                rsp_rd = mem_rd;
            end else if (!c_split_en) begin
                misalign_err = 1'b1;
            end else begin
                mem_memType = `MemTypeD;
                mem_addr    = w_line_base;
                mem_we      = req_we;
                mem_wd      = w_merge;
                if (w_cross) begin
                    req_ready  = 1'b0;
                    w_go_split = 1'b1;
                end else begin
                    rsp_rd = req_we ? 64'd0 : w_load;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_type      <= '0;
            r_off       <= '0;
            r_line      <= '0;
            r_wd        <= '0;
            r_we        <= 1'b0;
            r_lo_line   <= '0;
            r_split_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go_split) begin
                        r_state   <= S_SECOND;
                        r_type    <= req_memType;
                        r_off     <= req_addr[2:0];
                        r_line    <= req_addr[3 +: c_line_w];
                        r_wd      <= req_wd;
                        r_we      <= req_we;
                        r_lo_line <= mem_rd;
                    end
                end
                S_SECOND: begin
                    r_state     <= S_IDLE;
                    r_split_cnt <= r_split_cnt + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign split_cnt = r_split_cnt;

endmodule

`default_nettype wire
